// File: rtl/edge_detector_block_if.sv
// Level-in / pulse-out bundle between a level source and edge_detector_block.
// There is no handshake: signal_in is a free-running level and edge_detect_pulse a one-cycle strobe.
interface edge_detector_block_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] signal_in;
    logic [WIDTH-1:0] edge_detect_pulse;

    modport master (
        output signal_in,
        input  edge_detect_pulse
    );

    modport slave (
        input  signal_in,
        output edge_detect_pulse
    );
endinterface

// File: rtl/edge_detector_block.sv
// Per-bit edge detector producing registered one-cycle pulses (rising, falling or both edges).
// Optional macro EDGE_DETECTOR_SYNC_EN inserts a 2-flop synchronizer per bit ahead of the detector.
module edge_detector_block #(
    parameter int WIDTH     = 1,
    parameter int EDGE_TYPE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    edge_detector_block_if.slave  det_if
);

    localparam int MODE_FALL = 1;
    localparam int MODE_BOTH = 2;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] pulse_q;
    logic [WIDTH-1:0] pulse_d;

`ifdef EDGE_DETECTOR_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Synchronizer keeps shifting through reset so prev sees a settled level at release.
    always_ff @(posedge clk) begin
        sync1_q <= det_if.signal_in;
        sync2_q <= sync1_q;
    end

    assign s = sync2_q;
`else
    assign s = det_if.signal_in;
`endif

    always_comb begin
        prev_d = s;
        case (EDGE_TYPE)
            MODE_FALL: pulse_d = ~s & prev_q;
            MODE_BOTH: pulse_d = s ^ prev_q;
            default:   pulse_d = s & ~prev_q;
        endcase
    end

    // prev tracks s even in reset, so a level held through reset gives no pulse on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= '0;
            prev_q  <= prev_d;
        end else begin
            pulse_q <= pulse_d;
            prev_q  <= prev_d;
        end
    end

    assign det_if.edge_detect_pulse = pulse_q;

endmodule

// File: tb/tb_edge_detector_block.sv
// Bench for edge_detector_block: four instances (rising, falling, both, out-of-range mode) share one input.
// A sample-history reference model predicts every output cycle; honours EDGE_DETECTOR_SYNC_EN latency.
module tb_edge_detector_block;

    localparam int W = 4;
`ifdef EDGE_DETECTOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sig = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] in_hist[$];
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #4 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUTs ----------------
    edge_detector_block_if #(.WIDTH(W)) bus_r ();
    edge_detector_block_if #(.WIDTH(W)) bus_f ();
    edge_detector_block_if #(.WIDTH(W)) bus_b ();
    edge_detector_block_if #(.WIDTH(W)) bus_x ();

    assign bus_r.signal_in = sig;
    assign bus_f.signal_in = sig;
    assign bus_b.signal_in = sig;
    assign bus_x.signal_in = sig;

    edge_detector_block #(.WIDTH(W), .EDGE_TYPE(0)) dut_r (.clk(clk), .rst(rst), .det_if(bus_r));
    edge_detector_block #(.WIDTH(W), .EDGE_TYPE(1)) dut_f (.clk(clk), .rst(rst), .det_if(bus_f));
    edge_detector_block #(.WIDTH(W), .EDGE_TYPE(2)) dut_b (.clk(clk), .rst(rst), .det_if(bus_b));
    edge_detector_block #(.WIDTH(W), .EDGE_TYPE(3)) dut_x (.clk(clk), .rst(rst), .det_if(bus_x));

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
        end
    endtask

    // ---------------- driver + model ----------------
    // Called at a falling edge: drive, let one rising edge happen, predict, then compare at the next falling edge.
    task automatic step(input logic r, input logic [W-1:0] v);
        int           n;
        logic         known;
        logic [W-1:0] cur;
        logic [W-1:0] old;
        logic [W-1:0] e_rise;
        logic [W-1:0] e_fall;
        logic [W-1:0] e_both;
        rst = r;
        sig = v;
        @(posedge clk);
        in_hist.push_back(v);
        n      = in_hist.size();
        known  = (n >= LAT + 2);
        e_rise = '0;
        e_fall = '0;
        e_both = '0;
        if (!r && known) begin
            cur = in_hist[n - 1 - LAT];
            old = in_hist[n - 2 - LAT];
            for (int i = 0; i < W; i++) begin
                if (cur[i] == 1'b1 && old[i] == 1'b0) e_rise[i] = 1'b1;
                if (cur[i] == 1'b0 && old[i] == 1'b1) e_fall[i] = 1'b1;
                if (cur[i] != old[i])                  e_both[i] = 1'b1;
            end
        end
        if (r || known) begin
            exp_q.push_back(e_rise);
            exp_q.push_back(e_fall);
            exp_q.push_back(e_both);
            exp_q.push_back(e_rise);
        end
        @(negedge clk);
        if (r || known) begin
            check("rise", bus_r.edge_detect_pulse, exp_q.pop_front());
            check("fall", bus_f.edge_detect_pulse, exp_q.pop_front());
            check("both", bus_b.edge_detect_pulse, exp_q.pop_front());
            check("mode3", bus_x.edge_detect_pulse, exp_q.pop_front());
        end
    endtask

    task automatic hold(input logic r, input logic [W-1:0] v, input int cycles);
        for (int i = 0; i < cycles; i++) step(r, v);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           wait_n;
        logic [W-1:0] v;
        logic         r;

        @(negedge clk);
        hold(1'b1, 4'b0000, 4);
        hold(1'b0, 4'b0000, 3);

        // latency of a single rising edge on bit 0
        step(1'b0, 4'b0001);
        wait_n = 0;
        while (bus_r.edge_detect_pulse[0] !== 1'b1 && wait_n < 10) begin
            step(1'b0, 4'b0001);
            wait_n++;
        end
        check("latency", W'(wait_n), W'(LAT));
        hold(1'b0, 4'b0001, 4);

        // falling level on bit 0, then rise on bit 1
        hold(1'b0, 4'b0000, 4);
        hold(1'b0, 4'b0010, 4);
        hold(1'b0, 4'b0000, 4);

        // simultaneous edges
        hold(1'b0, 4'b0011, 4);
        hold(1'b0, 4'b0000, 4);

        // level held high through reset, then release
        hold(1'b0, 4'b1111, 2);
        hold(1'b1, 4'b1111, 4);
        hold(1'b0, 4'b1111, 4);
        hold(1'b0, 4'b0000, 4);

        // reset arriving while a pulse is out
        step(1'b0, 4'b0101);
        hold(1'b0, 4'b0101, LAT);
        step(1'b1, 4'b0101);
        hold(1'b1, 4'b0101, 3);
        hold(1'b0, 4'b0101, 3);

        // toggle every cycle
        for (int i = 0; i < 8; i++) step(1'b0, (i % 2 == 0) ? 4'b0000 : 4'b1111);

        // randomized phase with occasional reset bursts
        v = '0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) v = W'($urandom_range(0, (1 << W) - 1));
            r = ($urandom_range(0, 24) == 0);
            step(r, v);
        end
        hold(1'b0, v, 4);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
